// File: rtl/uart_tx_cfg_if.sv
// Request/handshake bundle between the TX controller and the UART transmitter.
interface uart_tx_cfg_if #(
  parameter int unsigned DBIT_MAX = 8
);
  logic                tx_start;
  logic [DBIT_MAX-1:0] din;
  logic [3:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic [1:0]          cfg_stop;
  logic                tx_ready;
  logic                tx_done_tick;

  modport master (
    output tx_start, din, cfg_dbits, cfg_parity, cfg_stop,
    input  tx_ready, tx_done_tick
  );

  modport slave (
    input  tx_start, din, cfg_dbits, cfg_parity, cfg_stop,
    output tx_ready, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DBIT_MAX data bits, none/even/odd parity,
// 1/1.5/2 stop bits, LSB first, paced by an oversampling s_tick.
module uart_tx_cfg #(
  parameter int unsigned DBIT_MAX   = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           s_tick,
  uart_tx_cfg_if.slave   bus,
  output logic           tx
);
  localparam int unsigned TW = $clog2(2 * OVERSAMPLE);
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t              state, state_next;
  logic [TW-1:0]       tick, tick_next, stop_last, stop_last_next, stop_sel;
  logic [BW-1:0]       nbit, nbit_next, dbits, dbits_next, dbits_clamp;
  logic [DBIT_MAX-1:0] shreg, shreg_next;
  logic                par_en, par_en_next, par_odd, par_odd_next, par_acc, par_acc_next;
  logic                tx_next, ready_next, done_next;
  logic                tick_last, advance;

  // Request decode: clamp the data width and pick the last stop-tick index.
  always_comb begin
    if (bus.cfg_dbits < 4'd5)                dbits_clamp = 4'd5;
    else if (bus.cfg_dbits > BW'(DBIT_MAX))  dbits_clamp = BW'(DBIT_MAX);
    else                                     dbits_clamp = bus.cfg_dbits;
    case (bus.cfg_stop)
      2'b00:   stop_sel = TW'(OVERSAMPLE - 1);
      2'b01:   stop_sel = TW'(3 * OVERSAMPLE / 2 - 1);
      default: stop_sel = TW'(2 * OVERSAMPLE - 1);
    endcase
  end

  assign tick_last = (state == S_STOP) ? (tick == stop_last) : (tick == TW'(OVERSAMPLE - 1));
  assign advance   = s_tick && tick_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      tick             <= '0;
      nbit             <= '0;
      dbits            <= '0;
      stop_last        <= '0;
      shreg            <= '0;
      par_en           <= 1'b0;
      par_odd          <= 1'b0;
      par_acc          <= 1'b0;
      tx               <= 1'b1;
      bus.tx_ready     <= 1'b1;
      bus.tx_done_tick <= 1'b0;
    end else begin
      state            <= state_next;
      tick             <= tick_next;
      nbit             <= nbit_next;
      dbits            <= dbits_next;
      stop_last        <= stop_last_next;
      shreg            <= shreg_next;
      par_en           <= par_en_next;
      par_odd          <= par_odd_next;
      par_acc          <= par_acc_next;
      tx               <= tx_next;
      bus.tx_ready     <= ready_next;
      bus.tx_done_tick <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bus.tx_start) state_next = S_START;
      S_START:  if (advance) state_next = S_DATA;
      S_DATA:   if (advance && (nbit == dbits - 4'd1)) state_next = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (advance) state_next = S_STOP;
      S_STOP:   if (advance) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; tx always carries the level of the bit being counted.
  always_comb begin
    tick_next      = tick;
    nbit_next      = nbit;
    dbits_next     = dbits;
    stop_last_next = stop_last;
    shreg_next     = shreg;
    par_en_next    = par_en;
    par_odd_next   = par_odd;
    par_acc_next   = par_acc;
    tx_next        = tx;
    done_next      = 1'b0;
    ready_next     = (state_next == S_IDLE);
    if (state == S_IDLE) begin
      if (bus.tx_start) begin
        shreg_next     = bus.din;
        dbits_next     = dbits_clamp;
        par_en_next    = (bus.cfg_parity == 2'b01) || (bus.cfg_parity == 2'b10);
        par_odd_next   = (bus.cfg_parity == 2'b10);
        stop_last_next = stop_sel;
        par_acc_next   = 1'b0;
        tick_next      = '0;
        nbit_next      = '0;
        tx_next        = 1'b0;
      end
    end else if (s_tick) begin
      tick_next = tick_last ? '0 : tick + TW'(1);
      if (tick_last) begin
        case (state)
          S_START: tx_next = shreg[0];
          S_DATA: begin
            shreg_next   = {1'b0, shreg[DBIT_MAX-1:1]};
            par_acc_next = par_acc ^ shreg[0];
            if (nbit == dbits - 4'd1) begin
              nbit_next = '0;
              tx_next   = par_en ? (par_acc ^ shreg[0] ^ par_odd) : 1'b1;
            end else begin
              nbit_next = nbit + 4'd1;
              tx_next   = shreg[1];
            end
          end
          S_PARITY: tx_next = 1'b1;
          S_STOP: begin
            tx_next   = 1'b1;
            done_next = 1'b1;
          end
          default: tx_next = 1'b1;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: frame table plus scoreboard of expected frames and a per-tick line model.
module tb_uart_tx_cfg;
  localparam int unsigned OS = 16;

  typedef struct {
    logic [7:0] din;
    logic [3:0] dbits;
    logic [1:0] par;
    logic [1:0] stop;
    int         nbits;
    int         has_par;
    logic       par_bit;
    int         stop_ticks;
    int         total;
  } vec_t;

  logic clk, reset_n, s_tick, tx;
  uart_tx_cfg_if #(.DBIT_MAX(8)) bus ();

  uart_tx_cfg #(.DBIT_MAX(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .bus(bus), .tx(tx)
  );

  int   n_tests = 0, n_fail = 0, acc_cnt = 0, done_seen = 0, tcount = 0;
  bit   chk_en = 0, m_busy = 0;
  logic exp_tx = 1'b1, exp_ready = 1'b1, exp_done = 1'b0;
  bit   seq[$];
  vec_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Expand a table record into one line level per s_tick.
  function automatic void build(input vec_t v);
    for (int k = 0; k < OS; k++) seq.push_back(1'b0);
    for (int b = 0; b < v.nbits; b++)
      for (int k = 0; k < OS; k++) seq.push_back(v.din[b]);
    if (v.has_par != 0)
      for (int k = 0; k < OS; k++) seq.push_back(v.par_bit);
    for (int k = 0; k < v.stop_ticks; k++) seq.push_back(1'b1);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      for (int t = 0; t < 4; t++) begin
        @(posedge clk);
        #1 s_tick = (t == 3);
      end
    end
  end

  // Line model: consumes one level per s_tick of an accepted frame.
  always @(posedge clk) begin
    exp_done = 1'b0;
    if (!reset_n) begin
      m_busy = 0;
      seq.delete();
      sb.delete();
      exp_tx = 1'b1;
      exp_ready = 1'b1;
    end else if (!m_busy) begin
      if (bus.tx_start) begin
        check("sb_has_frame", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          build(sb[0]);
          m_busy = 1;
          exp_tx = 1'b0;
          exp_ready = 1'b0;
          acc_cnt++;
        end
      end
    end else if (s_tick) begin
      void'(seq.pop_front());
      if (seq.size() == 0) begin
        m_busy = 0;
        exp_tx = 1'b1;
        exp_ready = 1'b1;
        exp_done = 1'b1;
      end else begin
        exp_tx = seq[0];
      end
    end
  end

  always @(posedge clk) begin
    if (bus.tx_ready === 1'b1) tcount = 0;
    else if (s_tick) tcount++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", 32'(tx), 32'(exp_tx));
      check("ready", 32'(bus.tx_ready), 32'(exp_ready));
      check("done", 32'(bus.tx_done_tick), 32'(exp_done));
      if (bus.tx_done_tick === 1'b1) begin
        done_seen++;
        if (sb.size() == 0) check("done_without_frame", 32'd1, 32'd0);
        else begin
          vec_t r;
          r = sb.pop_front();
          check("frame_ticks", 32'(tcount), 32'(r.total));
        end
      end
    end
  end

  task automatic send(input vec_t v, input bit keep);
    int start, n;
    start = acc_cnt;
    n = 0;
    sb.push_back(v);
    bus.din = v.din;
    bus.cfg_dbits = v.dbits;
    bus.cfg_parity = v.par;
    bus.cfg_stop = v.stop;
    bus.tx_start = 1'b1;
    while (acc_cnt == start && n < 5000) begin
      @(posedge clk);
      #1 n++;
    end
    if (acc_cnt == start) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept, required one within 5000 cycles");
    end
    if (!keep) bus.tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || sb.size() != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (m_busy || sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_timeout: got busy, required idle within 5000 cycles");
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'h55, 4'd8,  2'b00, 2'b00, 8, 0, 1'b0, 16, 160};
    vecs[1] = '{8'hC1, 4'd7,  2'b01, 2'b10, 7, 1, 1'b0, 32, 176};
    vecs[2] = '{8'hFF, 4'd8,  2'b10, 2'b01, 8, 1, 1'b1, 24, 184};
    vecs[3] = '{8'h1F, 4'd3,  2'b11, 2'b00, 5, 0, 1'b0, 16, 112};
    vecs[4] = '{8'hA5, 4'd12, 2'b01, 2'b11, 8, 1, 1'b0, 32, 192};
    vecs[5] = '{8'hE3, 4'd5,  2'b10, 2'b01, 5, 1, 1'b1, 24, 136};
    vecs[6] = '{8'h2D, 4'd6,  2'b01, 2'b11, 6, 1, 1'b0, 32, 160};
    vecs[7] = '{8'h01, 4'd8,  2'b10, 2'b00, 8, 1, 1'b0, 16, 176};

    reset_n = 1'b0;
    bus.tx_start = 1'b0;
    bus.din = '0;
    bus.cfg_dbits = 4'd8;
    bus.cfg_parity = 2'b00;
    bus.cfg_stop = 2'b00;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_done", 32'(bus.tx_done_tick), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i], 1'b0);
      wait_idle();
    end

    // Request while busy is dropped; the frame in flight keeps its latched data.
    send(vecs[0], 1'b0);
    repeat (150) @(posedge clk);
    #1;
    bus.din = 8'h00;
    bus.cfg_dbits = 4'd5;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #1 bus.tx_start = 1'b0;
    wait_idle();

    // Held request: second frame starts right after the done pulse.
    send(vecs[6], 1'b1);
    send(vecs[7], 1'b0);
    wait_idle();

    // One-cycle reset mid-DATA aborts the frame without a done pulse.
    send(vecs[1], 1'b0);
    repeat (120) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_ready", 32'(bus.tx_ready), 32'd1);
    repeat (800) @(posedge clk);
    #1;
    send(vecs[3], 1'b0);
    wait_idle();

    check("done_count", 32'(done_seen), 32'd12);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
